// File: rtl/mips_pipe_pkg.sv
// Shared types and constants for the 5-stage MIPS pipeline control blocks.
package mips_pipe_pkg;

  localparam int REG_W = 5;

  typedef logic [REG_W-1:0] reg_idx_t;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_ABORT    = 2'b10
  } hz_state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard controller.
// Optional perf-counter signals exist only when PIPE_PERF_CNT_EN is defined.
interface pipeline_hazard_ctrl_if;
  import mips_pipe_pkg::*;

  reg_idx_t   ID_RS;
  reg_idx_t   ID_RT;
  logic       ID_UsesRT;
  reg_idx_t   EX_RS;
  reg_idx_t   EX_RT;
  reg_idx_t   EX_RD;
  logic       EX_MEM_REN;
  logic       EX_BranchTaken;
  reg_idx_t   MEM_RD;
  logic       MEM_RegWrite;
  logic       MEM_MEM_REN;
  logic       MEM_MEM_WEN;
  reg_idx_t   WB_RD;
  logic       WB_RegWrite;
  // Memory handshake: an access is pending while MEM_MEM_REN|MEM_MEM_WEN is
  // high, and it completes on the first rising edge at which DMEM_Ready is 1.
  logic       DMEM_Ready;

  logic       PC_En;
  logic       IFID_En;
  logic       IDEX_En;
  logic       EXMEM_En;
  logic       MEMWB_En;
  logic       IFID_Flush;
  logic       IDEX_Flush;
  logic [1:0] FwdA;
  logic [1:0] FwdB;
  logic       MemErr;
  logic [1:0] State;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] StallCnt;
  logic [31:0] FlushCnt;
  logic [31:0] WaitCnt;
`endif

  modport master (
    output ID_RS, ID_RT, ID_UsesRT, EX_RS, EX_RT, EX_RD, EX_MEM_REN,
           EX_BranchTaken, MEM_RD, MEM_RegWrite, MEM_MEM_REN, MEM_MEM_WEN,
           WB_RD, WB_RegWrite, DMEM_Ready,
    input  PC_En, IFID_En, IDEX_En, EXMEM_En, MEMWB_En, IFID_Flush,
           IDEX_Flush, FwdA, FwdB, MemErr, State
`ifdef PIPE_PERF_CNT_EN
    , input StallCnt, FlushCnt, WaitCnt
`endif
  );

  modport slave (
    input  ID_RS, ID_RT, ID_UsesRT, EX_RS, EX_RT, EX_RD, EX_MEM_REN,
           EX_BranchTaken, MEM_RD, MEM_RegWrite, MEM_MEM_REN, MEM_MEM_WEN,
           WB_RD, WB_RegWrite, DMEM_Ready,
    output PC_En, IFID_En, IDEX_En, EXMEM_En, MEMWB_En, IFID_Flush,
           IDEX_Flush, FwdA, FwdB, MemErr, State
`ifdef PIPE_PERF_CNT_EN
    , output StallCnt, FlushCnt, WaitCnt
`endif
  );

endinterface

// File: rtl/hazard_fwd_unit.sv
// EX operand forwarding select for one source register; MEM beats WB, $0 never forwards.
module hazard_fwd_unit
  import mips_pipe_pkg::*;
(
  input  reg_idx_t   i_ex_src,
  input  reg_idx_t   i_mem_rd,
  input  logic       i_mem_regwrite,
  input  reg_idx_t   i_wb_rd,
  input  logic       i_wb_regwrite,
  output logic [1:0] o_fwd
);

  always_comb begin
    o_fwd = FWD_RF;
    if (i_mem_regwrite && (i_mem_rd != '0) && (i_mem_rd == i_ex_src)) begin
      o_fwd = FWD_MEM;
    end else if (i_wb_regwrite && (i_wb_rd != '0) && (i_wb_rd == i_ex_src)) begin
      o_fwd = FWD_WB;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forwarding controller for the 5-stage MIPS pipeline.
// Define PIPE_PERF_CNT_EN to add the StallCnt/FlushCnt/WaitCnt counters.
module pipeline_hazard_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int TMO_W       = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  pipeline_hazard_ctrl_if.slave hz
);

  hz_state_e        r_state;
  hz_state_e        w_state_nxt;
  logic [TMO_W-1:0] r_cnt;
  logic [TMO_W-1:0] w_cnt_nxt;
  logic             r_mem_err;
  logic             w_mem_err_set;

  logic       w_mem_access;
  logic       w_load_use;
  logic       w_freeze;
  logic       w_branch_flush;
  logic       w_stall;
  logic [4:0] w_en;
  logic [1:0] w_flush;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;

  assign w_mem_access = hz.MEM_MEM_REN | hz.MEM_MEM_WEN;
  assign w_load_use   = hz.EX_MEM_REN && (hz.EX_RD != '0) &&
                        ((hz.EX_RD == hz.ID_RS) || (hz.ID_UsesRT && (hz.EX_RD == hz.ID_RT)));

  hazard_fwd_unit u_fwd_a (
    .i_ex_src       (hz.EX_RS),
    .i_mem_rd       (hz.MEM_RD),
    .i_mem_regwrite (hz.MEM_RegWrite),
    .i_wb_rd        (hz.WB_RD),
    .i_wb_regwrite  (hz.WB_RegWrite),
    .o_fwd          (w_fwd_a)
  );

  hazard_fwd_unit u_fwd_b (
    .i_ex_src       (hz.EX_RT),
    .i_mem_rd       (hz.MEM_RD),
    .i_mem_regwrite (hz.MEM_RegWrite),
    .i_wb_rd        (hz.WB_RD),
    .i_wb_regwrite  (hz.WB_RegWrite),
    .o_fwd          (w_fwd_b)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state   <= ST_RUN;
      r_cnt     <= '0;
      r_mem_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_mem_err <= r_mem_err | w_mem_err_set;
    end
  end

  // Ready is tested before the timeout so a completion on the last allowed cycle wins.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_mem_err_set = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_mem_access && !hz.DMEM_Ready) begin
          w_state_nxt = ST_MEM_WAIT;
          w_cnt_nxt   = TMO_W'(1);
        end else begin
          w_cnt_nxt   = '0;
        end
      end
      ST_MEM_WAIT: begin
        if (hz.DMEM_Ready) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
        end else if (r_cnt == TMO_W'(MEM_TIMEOUT)) begin
          w_state_nxt   = ST_ABORT;
          w_cnt_nxt     = '0;
          w_mem_err_set = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + TMO_W'(1);
        end
      end
      ST_ABORT: begin
        w_state_nxt = ST_RUN;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = ST_RUN;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // ABORT never freezes: it is the one-cycle release after a timeout.
  always_comb begin
    w_freeze       = ((r_state == ST_RUN) && w_mem_access && !hz.DMEM_Ready) ||
                     ((r_state == ST_MEM_WAIT) && !hz.DMEM_Ready);
    w_branch_flush = !w_freeze && hz.EX_BranchTaken;
    w_stall        = !w_freeze && !hz.EX_BranchTaken && w_load_use;
    w_en           = 5'b11111;
    w_flush        = 2'b00;
    if (!reset) begin
      w_en    = 5'b00000;
      w_flush = 2'b11;
    end else if (w_freeze) begin
      w_en    = 5'b00000;
    end else if (w_branch_flush) begin
      w_flush = 2'b11;
    end else if (w_stall) begin
      w_en    = 5'b00111;
      w_flush = 2'b01;
    end
  end

  assign {hz.PC_En, hz.IFID_En, hz.IDEX_En, hz.EXMEM_En, hz.MEMWB_En} = w_en;
  assign {hz.IFID_Flush, hz.IDEX_Flush} = w_flush;
  assign hz.FwdA   = reset ? w_fwd_a : FWD_RF;
  assign hz.FwdB   = reset ? w_fwd_b : FWD_RF;
  assign hz.MemErr = r_mem_err;
  assign hz.State  = r_state;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;
  logic [31:0] r_wait_cnt;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_wait_cnt  <= '0;
    end else begin
      if (w_stall)           r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_branch_flush)    r_flush_cnt <= r_flush_cnt + 32'd1;
      if (r_state != ST_RUN) r_wait_cnt  <= r_wait_cnt + 32'd1;
    end
  end

  assign hz.StallCnt = r_stall_cnt;
  assign hz.FlushCnt = r_flush_cnt;
  assign hz.WaitCnt  = r_wait_cnt;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl (MEM_TIMEOUT=4).
module tb_pipeline_hazard_ctrl;

  logic clock;
  logic reset;
  int   checks;
  int   failures;

  // {PC,IFID,IDEX,EXMEM,MEMWB en, IFID/IDEX flush, FwdA, FwdB, State, MemErr}
  logic [13:0] exp_q[$];

  localparam logic [4:0] EN_ALL  = 5'b11111;
  localparam logic [4:0] EN_NONE = 5'b00000;
  localparam logic [4:0] EN_LU   = 5'b00111;

  pipeline_hazard_ctrl_if hz_if ();

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .TMO_W(3)) dut (
    .clock (clock),
    .reset (reset),
    .hz    (hz_if.slave)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    hz_if.ID_RS = '0; hz_if.ID_RT = '0; hz_if.ID_UsesRT = 1'b0;
    hz_if.EX_RS = '0; hz_if.EX_RT = '0; hz_if.EX_RD = '0;
    hz_if.EX_MEM_REN = 1'b0; hz_if.EX_BranchTaken = 1'b0;
    hz_if.MEM_RD = '0; hz_if.MEM_RegWrite = 1'b0;
    hz_if.MEM_MEM_REN = 1'b0; hz_if.MEM_MEM_WEN = 1'b0;
    hz_if.WB_RD = '0; hz_if.WB_RegWrite = 1'b0;
    hz_if.DMEM_Ready = 1'b1;
  endtask

  task automatic drive_load_use(input logic ren, input logic [4:0] ex_rd,
                                input logic [4:0] id_rs, input logic [4:0] id_rt,
                                input logic uses_rt);
    hz_if.EX_MEM_REN = ren; hz_if.EX_RD = ex_rd;
    hz_if.ID_RS = id_rs; hz_if.ID_RT = id_rt; hz_if.ID_UsesRT = uses_rt;
  endtask

  task automatic drive_mem(input logic ren, input logic wen, input logic rdy,
                           input logic br);
    hz_if.MEM_MEM_REN = ren; hz_if.MEM_MEM_WEN = wen;
    hz_if.DMEM_Ready = rdy; hz_if.EX_BranchTaken = br;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [13:0] mk(input logic [4:0] en, input logic [1:0] fl,
                                     input logic [1:0] fa, input logic [1:0] fb,
                                     input logic [1:0] st, input logic me);
    return {en, fl, fa, fb, st, me};
  endfunction

  function automatic logic [13:0] observe();
    return {hz_if.PC_En, hz_if.IFID_En, hz_if.IDEX_En, hz_if.EXMEM_En, hz_if.MEMWB_En,
            hz_if.IFID_Flush, hz_if.IDEX_Flush, hz_if.FwdA, hz_if.FwdB,
            hz_if.State, hz_if.MemErr};
  endfunction

  function automatic logic [1:0] fwd_model(input logic [4:0] src, input logic [4:0] mrd,
                                           input logic mrw, input logic [4:0] wrd,
                                           input logic wrw);
    if (mrw && mrd != 5'd0 && mrd == src) return 2'b10;
    if (wrw && wrd != 5'd0 && wrd == src) return 2'b01;
    return 2'b00;
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [13:0] exp_v, obs_v;
    reset = 1'b0;
    drive_idle();
    hz_if.MEM_RD = 5'd5; hz_if.MEM_RegWrite = 1'b1; hz_if.EX_RS = 5'd5; hz_if.EX_RT = 5'd5;
    drive_load_use(1'b1, 5'd3, 5'd3, 5'd0, 1'b0);
    repeat (2) @(posedge clock);
    exp_q.push_back(mk(EN_NONE, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0));
    @(negedge clock);
    exp_v = exp_q.pop_front(); obs_v = observe(); checks++;
    if (obs_v !== exp_v) begin
      failures++; $display("FAIL reset_outputs got=%h exp=%h", obs_v, exp_v);
    end
    next_cycle();
    reset = 1'b1;
    drive_idle();
    exp_q.push_back(mk(EN_ALL, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
    @(negedge clock);
    exp_v = exp_q.pop_front(); obs_v = observe(); checks++;
    if (obs_v !== exp_v) begin
      failures++; $display("FAIL reset_release got=%h exp=%h", obs_v, exp_v);
    end
    next_cycle();
  endtask

  task automatic test_load_use();
    logic [13:0] exp_v, obs_v;
    for (int i = 0; i < 6; i++) begin
      drive_idle();
      case (i)
        0: begin drive_load_use(1'b1, 5'd8, 5'd8, 5'd0, 1'b0); exp_q.push_back(mk(EN_LU, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0)); end
        1: begin drive_load_use(1'b0, 5'd0, 5'd8, 5'd0, 1'b0); exp_q.push_back(mk(EN_ALL, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0)); end
        2: begin drive_load_use(1'b1, 5'd0, 5'd0, 5'd0, 1'b1); exp_q.push_back(mk(EN_ALL, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0)); end
        3: begin drive_load_use(1'b1, 5'd9, 5'd4, 5'd9, 1'b1); exp_q.push_back(mk(EN_LU, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0)); end
        4: begin drive_load_use(1'b1, 5'd9, 5'd4, 5'd9, 1'b0); exp_q.push_back(mk(EN_ALL, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0)); end
        default: begin drive_load_use(1'b0, 5'd8, 5'd8, 5'd0, 1'b0); exp_q.push_back(mk(EN_ALL, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0)); end
      endcase
      @(negedge clock);
      exp_v = exp_q.pop_front(); obs_v = observe(); checks++;
      if (obs_v !== exp_v) begin
        failures++; $display("FAIL load_use[%0d] got=%h exp=%h", i, obs_v, exp_v);
      end
      next_cycle();
    end
  endtask

  task automatic test_forwarding();
    logic [13:0] exp_v, obs_v;
    logic [4:0]  rs, rt, mrd, wrd;
    logic        mrw, wrw;
    for (int i = 0; i < 29; i++) begin
      drive_idle();
      case (i)
        0: begin rs = 5; rt = 0; mrd = 5; mrw = 1; wrd = 5; wrw = 1; end
        1: begin rs = 5; rt = 0; mrd = 5; mrw = 0; wrd = 5; wrw = 1; end
        2: begin rs = 5; rt = 0; mrd = 5; mrw = 0; wrd = 5; wrw = 0; end
        3: begin rs = 5; rt = 7; mrd = 5; mrw = 1; wrd = 7; wrw = 1; end
        4: begin rs = 0; rt = 0; mrd = 0; mrw = 1; wrd = 0; wrw = 1; end
        default: begin
          rs  = 5'($urandom_range(0, 3)); rt  = 5'($urandom_range(0, 3));
          mrd = 5'($urandom_range(0, 3)); wrd = 5'($urandom_range(0, 3));
          mrw = 1'($urandom_range(0, 1)); wrw = 1'($urandom_range(0, 1));
        end
      endcase
      hz_if.EX_RS = rs; hz_if.EX_RT = rt;
      hz_if.MEM_RD = mrd; hz_if.MEM_RegWrite = mrw;
      hz_if.WB_RD = wrd; hz_if.WB_RegWrite = wrw;
      case (i)
        0: exp_q.push_back(mk(EN_ALL, 2'b00, 2'b10, 2'b00, 2'b00, 1'b0));
        1: exp_q.push_back(mk(EN_ALL, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0));
        2: exp_q.push_back(mk(EN_ALL, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
        3: exp_q.push_back(mk(EN_ALL, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0));
        4: exp_q.push_back(mk(EN_ALL, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
        default: exp_q.push_back(mk(EN_ALL, 2'b00, fwd_model(rs, mrd, mrw, wrd, wrw),
                                    fwd_model(rt, mrd, mrw, wrd, wrw), 2'b00, 1'b0));
      endcase
      @(negedge clock);
      exp_v = exp_q.pop_front(); obs_v = observe(); checks++;
      if (obs_v !== exp_v) begin
        failures++; $display("FAIL forward[%0d] rs=%0d rt=%0d got=%h exp=%h", i, rs, rt, obs_v, exp_v);
      end
      next_cycle();
    end
  endtask

  // Single wait released by Ready, a write with Ready on the trigger cycle,
  // then back-to-back reads where the second completes on the timeout cycle.
  task automatic test_mem_wait();
    logic [13:0] exp_v, obs_v;
    for (int i = 0; i < 14; i++) begin
      drive_idle();
      case (i)
        0:  begin drive_mem(1, 0, 0, 0); exp_q.push_back(mk(EN_NONE, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0)); end
        1:  begin drive_mem(1, 0, 0, 0); exp_q.push_back(mk(EN_NONE, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0)); end
        2:  begin drive_mem(1, 0, 0, 0); exp_q.push_back(mk(EN_NONE, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0)); end
        3:  begin drive_mem(1, 0, 1, 0); exp_q.push_back(mk(EN_ALL,  2'b00, 2'b00, 2'b00, 2'b01, 1'b0)); end
        4:  begin drive_mem(0, 1, 1, 0); exp_q.push_back(mk(EN_ALL,  2'b00, 2'b00, 2'b00, 2'b00, 1'b0)); end
        5:  begin drive_mem(1, 0, 0, 0); exp_q.push_back(mk(EN_NONE, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0)); end
        6:  begin drive_mem(1, 0, 0, 0); exp_q.push_back(mk(EN_NONE, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0)); end
        7:  begin drive_mem(1, 0, 1, 0); exp_q.push_back(mk(EN_ALL,  2'b00, 2'b00, 2'b00, 2'b01, 1'b0)); end
        8:  begin drive_mem(1, 0, 0, 0); exp_q.push_back(mk(EN_NONE, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0)); end
        9:  begin drive_mem(1, 0, 0, 0); exp_q.push_back(mk(EN_NONE, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0)); end
        10: begin drive_mem(1, 0, 0, 0); exp_q.push_back(mk(EN_NONE, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0)); end
        11: begin drive_mem(1, 0, 0, 0); exp_q.push_back(mk(EN_NONE, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0)); end
        12: begin drive_mem(1, 0, 1, 0); exp_q.push_back(mk(EN_ALL,  2'b00, 2'b00, 2'b00, 2'b01, 1'b0)); end
        default: begin drive_mem(0, 0, 1, 0); exp_q.push_back(mk(EN_ALL, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0)); end
      endcase
      @(negedge clock);
      exp_v = exp_q.pop_front(); obs_v = observe(); checks++;
      if (obs_v !== exp_v) begin
        failures++; $display("FAIL mem_wait[%0d] got=%h exp=%h", i, obs_v, exp_v);
      end
      next_cycle();
    end
  endtask

  task automatic test_simultaneous();
    logic [13:0] exp_v, obs_v;
    for (int i = 0; i < 5; i++) begin
      drive_idle();
      case (i)
        0: begin
          drive_load_use(1'b1, 5'd8, 5'd8, 5'd0, 1'b0); hz_if.EX_BranchTaken = 1'b1;
          exp_q.push_back(mk(EN_ALL, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0));
        end
        1: begin drive_mem(1, 0, 0, 1); exp_q.push_back(mk(EN_NONE, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0)); end
        2: begin drive_mem(1, 0, 0, 1); exp_q.push_back(mk(EN_NONE, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0)); end
        3: begin drive_mem(1, 0, 1, 1); exp_q.push_back(mk(EN_ALL,  2'b11, 2'b00, 2'b00, 2'b01, 1'b0)); end
        default: begin drive_mem(0, 0, 1, 0); exp_q.push_back(mk(EN_ALL, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0)); end
      endcase
      @(negedge clock);
      exp_v = exp_q.pop_front(); obs_v = observe(); checks++;
      if (obs_v !== exp_v) begin
        failures++; $display("FAIL simultaneous[%0d] got=%h exp=%h", i, obs_v, exp_v);
      end
      next_cycle();
    end
  endtask

  // Trigger plus four wait cycles, then ABORT releases even with the access still shown.
  task automatic test_timeout();
    logic [13:0] exp_v, obs_v;
    for (int i = 0; i < 9; i++) begin
      drive_idle();
      case (i)
        0: begin drive_mem(1, 0, 0, 0); exp_q.push_back(mk(EN_NONE, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0)); end
        1, 2, 3, 4: begin
          drive_mem(1, 0, 0, 0); exp_q.push_back(mk(EN_NONE, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0));
        end
        5: begin drive_mem(1, 0, 0, 0); exp_q.push_back(mk(EN_ALL, 2'b00, 2'b00, 2'b00, 2'b10, 1'b1)); end
        6: begin drive_mem(0, 0, 1, 0); exp_q.push_back(mk(EN_ALL, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1)); end
        7: begin drive_mem(1, 0, 1, 0); exp_q.push_back(mk(EN_ALL, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1)); end
        default: begin drive_mem(0, 0, 1, 0); exp_q.push_back(mk(EN_ALL, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1)); end
      endcase
      @(negedge clock);
      exp_v = exp_q.pop_front(); obs_v = observe(); checks++;
      if (obs_v !== exp_v) begin
        failures++; $display("FAIL timeout[%0d] got=%h exp=%h", i, obs_v, exp_v);
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [13:0] exp_v, obs_v;
    for (int i = 0; i < 7; i++) begin
      drive_idle();
      reset = 1'b1;
      case (i)
        0: begin drive_mem(1, 0, 0, 0); exp_q.push_back(mk(EN_NONE, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1)); end
        1: begin drive_mem(1, 0, 0, 0); exp_q.push_back(mk(EN_NONE, 2'b00, 2'b00, 2'b00, 2'b01, 1'b1)); end
        2: begin
          reset = 1'b0; drive_mem(1, 0, 0, 0);
          exp_q.push_back(mk(EN_NONE, 2'b11, 2'b00, 2'b00, 2'b01, 1'b1));
        end
        3: begin drive_mem(0, 0, 1, 0); exp_q.push_back(mk(EN_ALL, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0)); end
        4: begin drive_mem(1, 0, 0, 0); exp_q.push_back(mk(EN_NONE, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0)); end
        5: begin drive_mem(1, 0, 1, 0); exp_q.push_back(mk(EN_ALL, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0)); end
        default: begin drive_mem(0, 0, 1, 0); exp_q.push_back(mk(EN_ALL, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0)); end
      endcase
      @(negedge clock);
      exp_v = exp_q.pop_front(); obs_v = observe(); checks++;
      if (obs_v !== exp_v) begin
        failures++; $display("FAIL reset_mid_wait[%0d] got=%h exp=%h", i, obs_v, exp_v);
      end
`ifdef PIPE_PERF_CNT_EN
      if (i == 3) begin
        checks++;
        if (hz_if.WaitCnt !== 32'd0 || hz_if.StallCnt !== 32'd0 || hz_if.FlushCnt !== 32'd0) begin
          failures++;
          $display("FAIL perf_cnt_reset got=%0d/%0d/%0d exp=0/0/0",
                   hz_if.WaitCnt, hz_if.StallCnt, hz_if.FlushCnt);
        end
      end
`endif
      next_cycle();
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    drive_idle();
    test_reset();
    test_load_use();
    test_forwarding();
    test_mem_wait();
    test_simultaneous();
    test_timeout();
    test_reset_mid_wait();
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall, flush and forwarding controller for the 5-stage MIPS pipeline. Each cycle it drives the enables and flushes for PC, IF/ID, ID/EX, EX/MEM and MEM/WB, and the EX-stage operand forwarding selects. It resolves three conditions:
- load-use hazards, with a one-cycle bubble;
- taken-branch flushes;
- variable-latency data-memory accesses, by freezing the pipeline until the memory handshake completes or times out.

## Interface
Parameters:
- MEM_TIMEOUT, 255: maximum wait cycles allowed for one data-memory access before abort.
- TMO_W, 8: width of the wait counter; must satisfy 2^TMO_W > MEM_TIMEOUT.

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low reset.
- ID_RS, ID_RT  in  5 each  source registers of the instruction in ID.
- ID_UsesRT  in  1  ID instruction reads RT as a source.
- EX_RS, EX_RT, EX_RD  in  5 each  register fields of the instruction in EX.
- EX_MEM_REN  in  1  EX instruction is a load.
- EX_BranchTaken  in  1  branch/jump resolved taken in EX.
- MEM_RD  in  5  destination register of the MEM instruction.
- MEM_RegWrite  in  1  MEM instruction writes the register file.
- MEM_MEM_REN, MEM_MEM_WEN  in  1 each  MEM instruction accesses data memory.
- WB_RD  in  5  destination register of the WB instruction.
- WB_RegWrite  in  1  WB instruction writes the register file.
- DMEM_Ready  in  1  data memory completes the current access this cycle.
- PC_En, IFID_En, IDEX_En, EXMEM_En, MEMWB_En  out  1 each  stage-register load enables.
- IFID_Flush, IDEX_Flush  out  1 each  load a bubble (all zero) on the next edge.
- FwdA, FwdB  out  2 each  EX operand select: 00 = register file, 01 = WB result, 10 = MEM ALUResult.
- MemErr  out  1  sticky flag: a memory access timed out.
- State  out  2  current FSM state, for debug.

## Operation
- FSM states:
  - RUN (00): normal flow.
  - MEM_WAIT (01): waiting on an outstanding memory access.
  - ABORT (10): timeout release.
- Condition priority within a cycle: memory freeze, then branch flush, then load-use stall.
- Memory freeze:
  - Trigger, in RUN: (MEM_MEM_REN | MEM_MEM_WEN) & !DMEM_Ready.
  - Effect: all five enables go to 0 and no flushes are asserted. The FSM moves to MEM_WAIT and the wait counter loads 1.
  - In MEM_WAIT, while !DMEM_Ready: all enables stay 0 and the counter increments.
  - When DMEM_Ready=1: enables go to 1 and the FSM returns to RUN.
  - When the counter reaches MEM_TIMEOUT with !DMEM_Ready: the FSM moves to ABORT and MemErr is set.
  - In ABORT: enables go to 1 for one cycle, releasing the pipeline, then the FSM returns to RUN.
- Branch flush: EX_BranchTaken=1 with no freeze active → IFID_Flush=1, IDEX_Flush=1, all enables 1.
- Load-use stall:
  - Condition: EX_MEM_REN & (EX_RD!=0) & (EX_RD==ID_RS | (ID_UsesRT & EX_RD==ID_RT)), with no freeze and no branch flush.
  - Effect: PC_En=0, IFID_En=0, IDEX_Flush=1, all other enables 1.
  - Lasts exactly one cycle, because the load moves on to MEM.
- Forwarding (same rule for FwdB, using EX_RT):
  - FwdA=10 if MEM_RegWrite & MEM_RD!=0 & MEM_RD==EX_RS.
  - Otherwise FwdA=01 if WB_RegWrite & WB_RD!=0 & WB_RD==EX_RS.
  - Otherwise FwdA=00.
  - MEM takes priority over WB.
- Register $0 never triggers a stall or a forward.

## Timing
- Control and forwarding outputs are combinational from the current state and inputs. They take effect at the next clock edge. Zero-cycle latency.
- While reset=0 at an edge:
  - State ← RUN, counter ← 0, MemErr ← 0.
  - All outputs: enables 0, flushes 1, Fwd 00.
- Reset asserted mid-wait abandons the access; the FSM returns to RUN.
- A branch in EX during a freeze is held, because EX does not advance. The flush applies in the release cycle.
- DMEM_Ready=1 on the trigger cycle means no freeze occurs.
- DMEM_Ready arriving in the same cycle the counter reaches MEM_TIMEOUT counts as success; MemErr is not set.
- MemErr clears only on reset.
- Back-to-back memory accesses each restart the counter from 1.

## Configuration
- PIPE_PERF_CNT_EN defined: adds three outputs, each 32 bits, free-running, wrapping at 2^32, cleared on reset:
  - StallCnt: load-use cycles.
  - FlushCnt: branch-flush cycles.
  - WaitCnt: cycles spent in MEM_WAIT or ABORT.
- PIPE_PERF_CNT_EN undefined: none of these ports or registers exist. All other behaviour is identical.

## Structure
- Shared package mips_pipe_pkg:
  - FSM state encoding.
  - FWD_RF/FWD_WB/FWD_MEM select constants.
  - Register index width (5).
- Sub-module hazard_fwd_unit: purely combinational forwarding-select logic. It is instantiated twice, once for operand A and once for operand B.

## Test plan
- Load-use hazard: EX_MEM_REN=1, EX_RD=8, ID_RS=8 → exactly one cycle of PC_En=0, IFID_En=0, IDEX_Flush=1. With EX_RD=0, no stall.
- Forward priority: MEM_RD=WB_RD=EX_RS=5, both RegWrite=1 → FwdA=10. With MEM_RegWrite=0 → FwdA=01.
- Memory wait: MEM_MEM_REN=1, DMEM_Ready low for 3 cycles → all enables 0 for 3 cycles, State=01, then release with MemErr=0.
- Timeout: MEM_TIMEOUT=4, DMEM_Ready held 0 → ABORT after 4 wait cycles, one release cycle, MemErr=1 until reset.
- Simultaneous events:
  - Taken branch plus load-use in the same cycle → flush only, PC_En=1.
  - Branch during a freeze → flush asserted in the release cycle.
- Reset during MEM_WAIT (reset=0 for one edge) → State=00 and counter cleared. Under PIPE_PERF_CNT_EN, WaitCnt is also 0.
